// File: rtl/timer_array.sv
// Array of NCH independent down-counting timers with a shared register window.
// Each channel has a prescaler, three expiry modes and a pending flag that feeds a combined irq.
module timer_array #(
    parameter int NCH        = 2,
    parameter int CW         = 32,
    parameter int RST_PRESET = 128,
    localparam int AW        = (($clog2(NCH) > 1) ? $clog2(NCH) : 1) + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [31:0]   din,
    output logic [31:0]   dout,
    output logic          irq
);
    localparam int            CIW     = AW - 2;
    localparam logic [CW-1:0] RST_VAL = CW'(RST_PRESET);

    logic [CIW-1:0] ch_idx;
    logic [1:0]     reg_sel;

    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] im_q, im_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [1:0]     mode_q   [NCH];
    logic [1:0]     mode_d   [NCH];
    logic [3:0]     ps_q     [NCH];
    logic [3:0]     ps_d     [NCH];
    logic [3:0]     psc_q    [NCH];
    logic [3:0]     psc_d    [NCH];
    logic [CW-1:0]  preset_q [NCH];
    logic [CW-1:0]  preset_d [NCH];
    logic [CW-1:0]  count_q  [NCH];
    logic [CW-1:0]  count_d  [NCH];

    logic [NCH-1:0] ch_hit;
    logic [NCH-1:0] wr_ctrl, wr_preset, wr_count;
    logic [NCH-1:0] tick, set_pend, clr_pend;
    logic           wr_status;
    logic           din_unused;

    assign ch_idx     = addr[AW-1:2];
    assign reg_sel    = addr[1:0];
    assign din_unused = ^din;

    // Address decode; STATUS is global, so it ignores the channel index.
    always_comb begin
        ch_hit    = '0;
        wr_ctrl   = '0;
        wr_preset = '0;
        wr_count  = '0;
        wr_status = we && (reg_sel == 2'b11);
        clr_pend  = wr_status ? din[NCH-1:0] : '0;
        for (int i = 0; i < NCH; i++) begin
            ch_hit[i]    = (ch_idx == CIW'(i));
            wr_ctrl[i]   = we && ch_hit[i] && (reg_sel == 2'b00);
            wr_preset[i] = we && ch_hit[i] && (reg_sel == 2'b01);
            wr_count[i]  = we && ch_hit[i] && (reg_sel == 2'b10);
        end
    end

    always_comb begin
        en_d     = en_q;
        im_d     = im_q;
        mode_d   = mode_q;
        ps_d     = ps_q;
        psc_d    = psc_q;
        preset_d = preset_q;
        count_d  = count_q;
        tick     = '0;
        set_pend = '0;
        for (int i = 0; i < NCH; i++) begin
            tick[i]  = en_q[i] && (psc_q[i] == ps_q[i]);
            psc_d[i] = (!en_q[i] || tick[i]) ? 4'd0 : psc_q[i] + 4'd1;

            // A bus write to any of this channel's registers swallows the tick.
            if (tick[i] && !(wr_ctrl[i] || wr_preset[i] || wr_count[i])) begin
                if (count_q[i] != '0) begin
                    count_d[i] = count_q[i] - 1'b1;
                end else begin
                    set_pend[i] = 1'b1;
                    case (mode_q[i])
                        2'b01:   count_d[i] = preset_q[i];
                        2'b10:   count_d[i] = '1;
                        default: en_d[i]    = 1'b0;
                    endcase
                end
            end

            if (wr_ctrl[i]) begin
                en_d[i]   = din[0];
                mode_d[i] = din[2:1];
                im_d[i]   = din[3];
                ps_d[i]   = din[7:4];
                psc_d[i]  = 4'd0;
            end
            if (wr_preset[i]) begin
                preset_d[i] = din[CW-1:0];
            end
            if (wr_count[i]) begin
                count_d[i] = din[CW-1:0];
            end

            pend_d[i] = (pend_q[i] & ~clr_pend[i]) | set_pend[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                mode_q[i]   <= '0;
                ps_q[i]     <= '0;
                psc_q[i]    <= '0;
                preset_q[i] <= RST_VAL;
                count_q[i]  <= RST_VAL;
            end
        end else begin
            en_q     <= en_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            mode_q   <= mode_d;
            ps_q     <= ps_d;
            psc_q    <= psc_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        dout = '0;
        if (reg_sel == 2'b11) begin
            dout[NCH-1:0] = pend_q;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_hit[i]) begin
                    case (reg_sel)
                        2'b00:   dout[7:0]    = {ps_q[i], im_q[i], mode_q[i], en_q[i]};
                        2'b01:   dout[CW-1:0] = preset_q[i];
                        2'b10:   dout[CW-1:0] = count_q[i];
                        default: dout         = '0;
                    endcase
                end
            end
        end
    end

    assign irq = |(pend_q & im_q);

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array (NCH=3, CW=8): directed scenarios plus randomized traffic
// checked against a time-based behavioural model of the timers.
module tb_timer_array;
    localparam int NCH  = 3;
    localparam int CW   = 8;
    localparam int AW   = 4;
    localparam int MASK = (1 << CW) - 1;
    localparam int RSTV = 128 & MASK;

    logic          clk;
    logic          rst;
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic          irq;

    timer_array #(.NCH(NCH), .CW(CW), .RST_PRESET(128)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a channel started at edge t0 ticks on every edge c > t0 with (c - t0) % (ps + 1) == 0.
    int edge_n = 0;
    int m_en     [NCH];
    int m_mode   [NCH];
    int m_im     [NCH];
    int m_ps     [NCH];
    int m_preset [NCH];
    int m_count  [NCH];
    int m_pend   [NCH];
    int m_t0     [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic m_irq();
        logic r = 1'b0;
        for (int i = 0; i < NCH; i++) if (m_pend[i] != 0 && m_im[i] != 0) r = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        int idx = int'(a[3:2]);
        int sel = int'(a[1:0]);
        logic [31:0] r = '0;
        if (sel == 3) begin
            for (int i = 0; i < NCH; i++) r[i] = (m_pend[i] != 0);
        end else if (idx < NCH) begin
            case (sel)
                0: r = 32'(m_en[idx] + 2 * m_mode[idx] + 8 * m_im[idx] + 16 * m_ps[idx]);
                1: r = 32'(m_preset[idx]);
                default: r = 32'(m_count[idx]);
            endcase
        end
        return r;
    endfunction

    task automatic model_edge();
        int  idx, sel;
        bit  tick, wrch, setp;
        edge_n++;
        idx = int'(addr[3:2]);
        sel = int'(addr[1:0]);
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_en[i] = 0; m_mode[i] = 0; m_im[i] = 0; m_ps[i] = 0;
                m_preset[i] = RSTV; m_count[i] = RSTV; m_pend[i] = 0; m_t0[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                wrch = we && sel != 3 && idx == i;
                tick = m_en[i] != 0 && edge_n > m_t0[i] && ((edge_n - m_t0[i]) % (m_ps[i] + 1)) == 0;
                setp = 0;
                if (tick && !wrch) begin
                    if (m_count[i] != 0) m_count[i] = m_count[i] - 1;
                    else begin
                        setp = 1;
                        if (m_mode[i] == 1)      m_count[i] = m_preset[i];
                        else if (m_mode[i] == 2) m_count[i] = MASK;
                        else                     m_en[i] = 0;
                    end
                end
                if (wrch) begin
                    case (sel)
                        0: begin
                            m_en[i] = int'(din[0]); m_mode[i] = int'(din[2:1]);
                            m_im[i] = int'(din[3]); m_ps[i] = int'(din[7:4]); m_t0[i] = edge_n;
                        end
                        1: m_preset[i] = int'(din) & MASK;
                        default: m_count[i] = int'(din) & MASK;
                    endcase
                end
                if (we && sel == 3 && din[i]) m_pend[i] = 0;
                if (setp) m_pend[i] = 1;
            end
        end
    endtask

    task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic r = 1'b0);
        rst = r; we = w; addr = a; din = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("irq", {31'b0, irq}, {31'b0, m_irq()});
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] v);
        we = 1'b0; addr = a;
        #1;
        v = dout;
    endtask

    task automatic peek(input logic [AW-1:0] a);
        logic [31:0] v;
        rd(a, v);
        chk($sformatf("rd_%0h", a), v, exp_rd(a));
    endtask

    task automatic chk_all();
        for (int a = 0; a < 16; a++) peek(AW'(a));
    endtask

    logic [31:0] v;
    logic        rw, rr;
    logic [3:0]  ra;
    logic [31:0] rdat;

    initial begin
        rst = 1'b1; we = 1'b0; addr = '0; din = '0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < NCH; i++) begin
            rd(AW'(4 * i),     v); chk("rst_ctrl", v, 32'h0);
            rd(AW'(4 * i + 1), v); chk("rst_preset", v, 32'h80);
            rd(AW'(4 * i + 2), v); chk("rst_count", v, 32'h80);
        end
        rd(4'h3, v); chk("rst_status", v, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // One-shot, PS=0: expiry on the 4th edge after enabling
        cyc(1, 4'h1, 3); cyc(1, 4'h2, 3); cyc(1, 4'h0, 32'h9);
        repeat (3) cyc(0, 0, 0);
        rd(4'h3, v); chk("os_early", v, 32'h0);
        cyc(0, 0, 0);
        rd(4'h3, v); chk("os_pend", v, 32'h1);
        chk("os_irq", {31'b0, irq}, 32'h1);
        rd(4'h2, v); chk("os_count", v, 32'h0);
        rd(4'h0, v); chk("os_ctrl", v, 32'h8);
        cyc(1, 4'h3, 1);
        chk_all();

        // Auto-reload on ch1 with PRESET=COUNT=2: expiry every third edge, set beats clear
        cyc(1, 4'h5, 2); cyc(1, 4'h6, 2); cyc(1, 4'h4, 32'h0B);
        repeat (3) cyc(0, 0, 0);
        rd(4'h3, v); chk("ar_pend", v, 32'h2);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 4'h3, 2);
        rd(4'h3, v); chk("ar_setwins", v, 32'h2);
        cyc(1, 4'h3, 2);
        rd(4'h3, v); chk("ar_cleared", v, 32'h0);
        chk("ar_irq_low", {31'b0, irq}, 32'h0);
        cyc(1, 4'h4, 0);
        chk_all();

        // Prescale PS=3 with COUNT=1: expiry after 8 edges; CTRL rewrite restarts prescale
        cyc(1, 4'h2, 1); cyc(1, 4'h0, 32'h39);
        repeat (7) cyc(0, 0, 0);
        rd(4'h3, v); chk("ps_early", v, 32'h0);
        cyc(0, 0, 0);
        rd(4'h3, v); chk("ps_pend", v, 32'h1);
        cyc(1, 4'h3, 1);
        cyc(1, 4'h2, 1); cyc(1, 4'h0, 32'h39);
        repeat (2) cyc(0, 0, 0);
        cyc(1, 4'h0, 32'h39);
        repeat (7) cyc(0, 0, 0);
        rd(4'h3, v); chk("ps_restart_early", v, 32'h0);
        cyc(0, 0, 0);
        rd(4'h3, v); chk("ps_restart_pend", v, 32'h1);
        cyc(1, 4'h3, 1);

        // Free-run from 0: wraps to all-ones, PEND without irq when IM=0
        cyc(1, 4'h2, 0); cyc(1, 4'h0, 32'h05);
        cyc(0, 0, 0);
        rd(4'h2, v); chk("fr_wrap", v, 32'hFF);
        rd(4'h3, v); chk("fr_status", v, 32'h1);
        chk("fr_irq", {31'b0, irq}, 32'h0);
        cyc(1, 4'h0, 0); cyc(1, 4'h3, 1);
        chk_all();

        // Out-of-range channel index
        cyc(1, 4'hD, 32'h55);
        rd(4'hD, v); chk("oor_read", v, 32'h0);

        // Cross-channel independence, then reset overriding a write
        cyc(1, 4'hA, 0); cyc(1, 4'h8, 32'h09);
        cyc(1, 4'h6, 40); cyc(1, 4'h4, 32'h03);
        cyc(1, 4'h2, 50); cyc(1, 4'h0, 32'h01);
        repeat (3) cyc(0, 0, 0);
        cyc(1, 4'h6, 32'h77);
        rd(4'h6, v); chk("x_ch1_held", v, 32'h77);
        rd(4'h2, v); chk("x_ch0_run", v, 32'd46);
        chk("x_irq", {31'b0, irq}, 32'h1);
        cyc(1, 4'h2, 5, 1);
        cyc(0, 0, 0);
        for (int i = 0; i < NCH; i++) begin
            rd(AW'(4 * i),     v); chk("rst2_ctrl", v, 32'h0);
            rd(AW'(4 * i + 2), v); chk("rst2_count", v, 32'h80);
        end
        rd(4'h3, v); chk("rst2_status", v, 32'h0);
        chk("rst2_irq", {31'b0, irq}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 2500; n++) begin
            rr   = ($urandom_range(0, 299) == 0);
            rw   = ($urandom_range(0, 3) == 0);
            ra   = 4'($urandom_range(0, 15));
            rdat = $urandom;
            if ($urandom_range(0, 1) == 1) rdat = 32'($urandom_range(0, 6));
            if (ra[1:0] == 2'b00 && $urandom_range(0, 1) == 1) rdat = rdat & 32'h3F;
            cyc(rw, ra, rdat, rr);
            peek(4'($urandom_range(0, 15)));
            if (n % 100 == 99) chk_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/timer_array.md
TIMER_ARRAY -- requirements
Module: timer_array

Interface
REQ-001 Parameter NCH, default 2, number of independent timer channels (1..8).
REQ-002 Parameter CW, default 32, counter/preset width in bits (8..32).
REQ-003 Parameter RST_PRESET, default 128, reset value of every PRESET and COUNT, truncated to CW bits.
REQ-004 Localparam AW = max(1, clog2(NCH)) + 2, word-address width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 addr  input  AW  word address: addr[AW-1:2] = channel index, addr[1:0] = register select.
REQ-008 we  input  1  write strobe; din is written to the addressed register on the next rising edge.
REQ-009 din  input  32  write data.
REQ-010 dout  output  32  combinational read data of the addressed register.
REQ-011 irq  output  1  level interrupt request, OR over all channels.

Function
REQ-012 Each channel SHALL hold CTRL, PRESET and COUNT, and a PEND flag.
REQ-013 Register select: 00 CTRL, 01 PRESET, 10 COUNT, 11 STATUS; STATUS is global and is the same register at every channel index.
REQ-014 CTRL fields SHALL be: [0] EN; [2:1] MODE; [3] IM (interrupt enable); [7:4] PS (prescale); [31:8] read as 0 and ignore writes.
REQ-015 MODE SHALL be: 00 one-shot; 01 auto-reload; 10 free-run; 11 decodes as 00.
REQ-016 A channel SHALL tick once every PS+1 clk cycles while EN=1, using a 4-bit prescale counter.
REQ-017 The prescale counter SHALL clear when EN=0 and on any write to that channel's CTRL; the first tick after enabling occurs PS+1 cycles after EN is set.
REQ-018 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-019 On a tick with COUNT == 0 (expiry), behaviour by MODE: one-shot clears EN and sets PEND; auto-reload loads PRESET into COUNT and sets PEND; free-run wraps COUNT to all-ones (CW bits) and sets PEND.
REQ-020 Expiry SHALL occur exactly (COUNT_initial + 1) ticks after enabling.
REQ-021 A PRESET value of 0 in auto-reload SHALL give an expiry on every tick.
REQ-022 Bus writes to a channel SHALL take priority over that channel's tick in the same cycle; a written COUNT is not decremented in that cycle, and other channels continue counting unaffected.
REQ-023 PRESET and COUNT writes SHALL take din[CW-1:0]; reads SHALL zero-extend to 32 bits.
REQ-024 STATUS read SHALL return PEND[NCH-1:0] in bits [NCH-1:0], with zero in the upper bits.
REQ-025 A STATUS write SHALL be write-1-to-clear on PEND bits; if set and clear hit the same channel in one cycle, set SHALL win.
REQ-026 irq SHALL equal OR over channels of (PEND[i] & IM[i]), derived combinationally from registered state with no added latency.
REQ-027 Clearing IM SHALL deassert that channel's contribution to irq immediately but SHALL NOT clear PEND.
REQ-028 Accesses with channel index >= NCH SHALL read 0 (except STATUS) and writes SHALL be ignored.

Reset
REQ-029 Synchronous rst=1 SHALL set, for every channel: CTRL=0, PRESET=COUNT=RST_PRESET, PEND=0, prescale counter=0.
REQ-030 While rst=1, irq SHALL be 0 from the following edge onward; rst SHALL override any simultaneous we.
REQ-031 Reset asserted mid-count SHALL abort counting, and no expiry SHALL be reported for that count.

Verification
REQ-032 Ch0: PRESET=3, COUNT=3, CTRL=0x9 (one-shot, IM, PS=0) -> expiry 4 cycles after the write edge; then EN=0, PEND0=1, irq=1, COUNT holds 0.
REQ-033 Ch1: CTRL=0x0B (auto-reload, IM), PRESET=COUNT=2 -> PEND1 set every 3 cycles; a STATUS write of 0x2 clears it, and irq drops the next cycle unless it coincides with an expiry (set wins).
REQ-034 Ch0: PS=3, COUNT=1, EN=1 -> expiry after 8 cycles; a CTRL rewrite mid-run restarts the prescale.
REQ-035 Ch0 free-run, CW=8, COUNT=0 -> COUNT reads 0xFF after 1 tick and PEND0=1; with IM=0, irq stays 0 while STATUS reads 0x1.
REQ-036 Ch0 counting while ch1 COUNT is written -> ch0 decrements uninterrupted; ch1 holds the written value that cycle; rst pulse -> all registers at reset values and irq=0.
